// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key input blocks.
// Holds the debounce FSM state encoding and 50 MHz default counts.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } key_state_t;

    localparam int unsigned KEY_DEBOUNCE_50M = 1000000;
    localparam int unsigned KEY_LONG_50M     = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports: sys_clk, sys_rst (sync, active-high), d (async in), q (synced out).
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Push-button debouncer with registered level, press, release and long-press.
// Ports: sys_clk, sys_rst (sync, active-high), key_in (raw pin),
//        key_level, key_press, key_release, key_long (registered outputs).
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CNT   = KEY_DEBOUNCE_50M,
    parameter int unsigned LONG_CNT       = KEY_LONG_50M,
    parameter int unsigned KEY_ACTIVE_LOW = 1,
    parameter int unsigned CNT_W          = 32
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic IDLE_PIN = (KEY_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_CNT - 1);

    logic pin_s;
    logic k;

    key_state_t state, state_nxt;
    logic [CNT_W-1:0] dcnt, dcnt_nxt;
    logic [CNT_W-1:0] lcnt, lcnt_nxt;
    logic long_done, done_nxt;
    logic level_nxt, press_nxt, release_nxt, long_nxt;

    // Reset loads the idle pin level so a held key is seen as a new press.
    sync_2ff #(
        .RST_VAL(IDLE_PIN)
    ) u_sync (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .d      (key_in),
        .q      (pin_s)
    );

    assign k = pin_s ^ IDLE_PIN;

    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        lcnt_nxt    = lcnt;
        done_nxt    = long_done;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (k) begin
                    state_nxt = PRESS_CHK;
                    dcnt_nxt  = '0;
                end
            end
            PRESS_CHK: begin
                if (!k) begin
                    state_nxt = IDLE;
                end else if (dcnt == D_LAST) begin
                    state_nxt = HELD;
                    press_nxt = 1'b1;
                    lcnt_nxt  = '0;
                    done_nxt  = 1'b0;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            HELD: begin
                if (!k) begin
                    state_nxt = RELEASE_CHK;
                    dcnt_nxt  = '0;
                end else if (!long_done) begin
                    if (lcnt == L_LAST) begin
                        long_nxt = 1'b1;
                        done_nxt = 1'b1;
                    end else begin
                        lcnt_nxt = lcnt + 1'b1;
                    end
                end
            end
            RELEASE_CHK: begin
                // lcnt is left untouched so a bounce only pauses it.
                if (k) begin
                    state_nxt = HELD;
                end else if (dcnt == D_LAST) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
        endcase
        level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_CHK);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            dcnt        <= '0;
            lcnt        <= '0;
            long_done   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_nxt;
            dcnt        <= dcnt_nxt;
            lcnt        <= lcnt_nxt;
            long_done   <= done_nxt;
            key_level   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: active-low and active-high builds in lockstep.
// Ports: none; drives both instances from one "pressed" stimulus.
module tb_key_debounce;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_l   = 1'b1;
    logic key_h   = 1'b0;

    logic lvl_l, pr_l, rl_l, lg_l;
    logic lvl_h, pr_h, rl_h, lg_h;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic key;
        logic lvl;
        logic pr;
        logic rl;
        logic lg;
    } vec_t;

    vec_t tbl[20];

    always #5 sys_clk = ~sys_clk;

    key_debounce #(
        .DEBOUNCE_CNT  (4),
        .LONG_CNT      (20),
        .KEY_ACTIVE_LOW(1),
        .CNT_W         (8)
    ) u_low (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_l),
        .key_level  (lvl_l),
        .key_press  (pr_l),
        .key_release(rl_l),
        .key_long   (lg_l)
    );

    key_debounce #(
        .DEBOUNCE_CNT  (4),
        .LONG_CNT      (20),
        .KEY_ACTIVE_LOW(0),
        .CNT_W         (8)
    ) u_high (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_h),
        .key_level  (lvl_h),
        .key_press  (pr_h),
        .key_release(rl_h),
        .key_long   (lg_h)
    );

    // Drive inputs, take one rising edge, then compare both builds.
    task automatic tick(
        input logic  pressed,
        input logic  rst,
        input logic  e_lvl,
        input logic  e_pr,
        input logic  e_rl,
        input logic  e_lg,
        input string name
    );
        logic [3:0] exp_v, got_l, got_h;
        key_l   = ~pressed;
        key_h   = pressed;
        sys_rst = rst;
        @(posedge sys_clk);
        #1;
        exp_v = {e_lvl, e_pr, e_rl, e_lg};
        got_l = {lvl_l, pr_l, rl_l, lg_l};
        got_h = {lvl_h, pr_h, rl_h, lg_h};
        checks++;
        if (got_l !== exp_v) begin
            errors++;
            $display("FAIL %s low cyc=%0d got=%b want=%b", name, cyc, got_l, exp_v);
        end
        checks++;
        if (got_h !== exp_v) begin
            errors++;
            $display("FAIL %s high cyc=%0d got=%b want=%b", name, cyc, got_h, exp_v);
        end
        cyc++;
    endtask

    initial begin
        // 0..7: 3-cycle bounce, never accepted.
        for (int i = 0; i < 8; i++) begin
            tbl[i].key = (i < 3);
            tbl[i].lvl = 1'b0;
            tbl[i].pr  = 1'b0;
            tbl[i].rl  = 1'b0;
            tbl[i].lg  = 1'b0;
        end
        // 8..19: steady press from edge 8; press pulse after edge 8+6.
        for (int i = 8; i < 20; i++) begin
            tbl[i].key = 1'b1;
            tbl[i].lvl = (i >= 14);
            tbl[i].pr  = (i == 14);
            tbl[i].rl  = 1'b0;
            tbl[i].lg  = 1'b0;
        end

        for (int j = 0; j < 3; j++)
            tick(1'b0, 1'b1, 0, 0, 0, 0, "reset");

        for (int i = 0; i < 20; i++)
            tick(tbl[i].key, 1'b0, tbl[i].lvl, tbl[i].pr,
                 tbl[i].rl, tbl[i].lg, "table");

        // Long press at table edge 8 + 6 + 20 = 34, then never again.
        for (int j = 20; j < 135; j++)
            tick(1'b1, 1'b0, 1, 0, 0, (j == 34), "long");

        for (int j = 0; j < 10; j++)
            tick(1'b0, 1'b0, (j < 6), 0, (j == 6), 0, "release1");

        // 2-cycle glitch spends 3 edges outside HELD counting: long at 26+3.
        for (int j = 0; j < 41; j++)
            tick(!(j == 11 || j == 12), 1'b0, (j >= 6), (j == 6),
                 0, (j == 29), "glitch");

        for (int j = 0; j < 10; j++)
            tick(1'b0, 1'b0, (j < 6), 0, (j == 6), 0, "release2");

        // Reset mid-PRESS_CHK at 4 and mid-HELD at 14; press R+7 later.
        for (int j = 0; j < 31; j++)
            tick(1'b1, (j == 4 || j == 14),
                 ((j >= 11 && j < 14) || j >= 21),
                 (j == 11 || j == 21), 0, 0, "rst_mid");

        for (int j = 0; j < 10; j++)
            tick(1'b0, 1'b0, (j < 6), 0, (j == 6), 0, "release3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
